// File: rtl/reg_write_master_if.sv
// reg_write_master_if: command, write-data and register-bus signals of the write master
interface reg_write_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_incr;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              xfc;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_incr, wr_valid, wr_data,
        output cmd_ready, wr_ready, address, wdata, xfc, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_incr, wr_valid, wr_data,
        input  cmd_ready, wr_ready, address, wdata, xfc, busy, done
    );
endinterface

// File: rtl/reg_write_master.sv
// reg_write_master: register-bus write initiator with setup/strobe/gap timing and bursts
module reg_write_master #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 4,
    parameter int SETUP_CYC = 1,
    parameter int GAP_CYC   = 2
) (
    input logic clk,
    input logic rst,
    reg_write_master_if.master bus
);
    localparam int TW = 16;
    // Timers count down to zero, so they load the cycle count minus one
    localparam logic [TW-1:0] SETUP_T = TW'(SETUP_CYC > 1 ? SETUP_CYC - 1 : 0);
    localparam logic [TW-1:0] GAP_T   = TW'(GAP_CYC > 1 ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, SETUP, STROBE, GAP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic              incr_q, incr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              xfc_q, xfc_d;
    logic              done_q, done_d;

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        beats_d   = beats_q;
        incr_d    = incr_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                address_d = bus.cmd_addr;
                beats_d   = bus.cmd_len;
                incr_d    = bus.cmd_incr;
                state_d   = WAIT_DATA;
            end
            WAIT_DATA: if (bus.wr_valid) begin
                wdata_d = bus.wr_data;
                timer_d = SETUP_T;
                state_d = (SETUP_CYC == 0) ? STROBE : SETUP;
            end
            SETUP: if (timer_q == '0) state_d = STROBE;
                   else timer_d = timer_q - TW'(1);
            STROBE: begin
                timer_d = GAP_T;
                state_d = GAP;
            end
            GAP: if (timer_q != '0) timer_d = timer_q - TW'(1);
                 else if (beats_q != '0) begin
                     beats_d   = beats_q - LEN_W'(1);
                     address_d = address_q + ADDR_W'(incr_q);
                     state_d   = WAIT_DATA;
                 end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                 end
            default: state_d = IDLE;
        endcase
        xfc_d = state_d == STROBE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            address_q <= '0;
            wdata_q   <= '0;
            beats_q   <= '0;
            incr_q    <= 1'b0;
            timer_q   <= '0;
            xfc_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            beats_q   <= beats_d;
            incr_q    <= incr_d;
            timer_q   <= timer_d;
            xfc_q     <= xfc_d;
            done_q    <= done_d;
        end
    end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.wr_ready  = state_q == WAIT_DATA;
    assign bus.busy      = state_q != IDLE;
    assign bus.address   = address_q;
    assign bus.wdata     = wdata_q;
    assign bus.xfc       = xfc_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_reg_write_master.sv
// tb_reg_write_master: directed checks of write timing, bursts, backpressure and reset
module tb_reg_write_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    reg_write_master_if #(.ADDR_W(12), .DATA_W(8), .LEN_W(4)) bus ();
    reg_write_master_if #(.ADDR_W(12), .DATA_W(8), .LEN_W(4)) bus2 ();

    reg_write_master #(.ADDR_W(12), .DATA_W(8), .LEN_W(4), .SETUP_CYC(1), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    reg_write_master #(.ADDR_W(12), .DATA_W(8), .LEN_W(4), .SETUP_CYC(0), .GAP_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master)
    );

    typedef struct {
        int         c;
        logic [11:0] a;
        logic [7:0]  d;
    } ev_t;
    ev_t xlog[$];
    int  dlog[$];

    logic        p_xfc = 1'b0;
    logic [11:0] p_a = '0;
    logic [7:0]  p_d = '0;

    // Records every strobe/done and flags bus changes around a strobe
    always @(negedge clk) begin
        if (!rst) p_xfc = 1'b0;
        else begin
            if (bus.xfc) begin
                xlog.push_back('{cyc, bus.address, bus.wdata});
                if (p_xfc || bus.address !== p_a || bus.wdata !== p_d) begin
                    viol++;
                    $display("stability violation at strobe cycle %0d", cyc);
                end
            end
            if (p_xfc && (bus.address !== p_a || bus.wdata !== p_d)) begin
                viol++;
                $display("stability violation after strobe cycle %0d", cyc);
            end
            if (bus.done) dlog.push_back(cyc);
            p_xfc = bus.xfc;
            p_a   = bus.address;
            p_d   = bus.wdata;
        end
    end

    task automatic send_cmd(input logic [11:0] a, input logic [3:0] l, input logic inc, output int acc);
        int g = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_incr  = inc;
        while (!bus.cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        acc = cyc + 1;
        checks++;
        if (g >= 200) begin
            errors++;
            $display("FAIL cmd_accept: no cmd_ready after %0d cycles, required within 200", g);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic feed(input int n, input logic [7:0] base, input int stall);
        int k = 0;
        int s = stall;
        int g = 0;
        while (k < n && g < 500) begin
            @(negedge clk);
            g++;
            if (bus.wr_ready && s == 0) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = base + 8'(k);
                k++;
            end else begin
                bus.wr_valid = 1'b0;
                if (bus.wr_ready) s--;
            end
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        checks++;
        if (k !== n) begin
            errors++;
            $display("FAIL feed: %0d beats accepted, required %0d", k, n);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.xfc, bus.done, bus.busy, bus.address, bus.wdata} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: xfc=%b done=%b busy=%b addr=%h wdata=%h, required all 0",
                     bus.xfc, bus.done, bus.busy, bus.address, bus.wdata);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b wr_ready=%b, required 1/0", bus.cmd_ready, bus.wr_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: busy=%b cmd_ready=%b, required 0/1", bus.busy, bus.cmd_ready);
        end
    endtask

    task automatic test_single();
        int acc;
        int x0 = xlog.size();
        int d0 = dlog.size();
        fork
            send_cmd(12'h00C, 4'd0, 1'b0, acc);
            feed(1, 8'h01, 0);
        join
        repeat (6) @(negedge clk);
        checks++;
        if (xlog.size() - x0 !== 1) begin
            errors++;
            $display("FAIL single_count: %0d strobes, required 1", xlog.size() - x0);
        end else begin
            checks++;
            if (xlog[x0].c !== acc + 2 || xlog[x0].a !== 12'h00C || xlog[x0].d !== 8'h01) begin
                errors++;
                $display("FAIL single_beat: cyc=%0d addr=%h data=%h, required cyc=%0d addr=00c data=01",
                         xlog[x0].c, xlog[x0].a, xlog[x0].d, acc + 2);
            end
        end
        checks++;
        if (dlog.size() - d0 !== 1 || dlog[d0] !== acc + 5) begin
            errors++;
            $display("FAIL single_done: %0d pulses, first at %0d, required 1 at %0d",
                     dlog.size() - d0, dlog.size() > d0 ? dlog[d0] : -1, acc + 5);
        end
        checks++;
        if (bus.wdata !== 8'h01 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: wdata=%h busy=%b, required 01/0", bus.wdata, bus.busy);
        end
    endtask

    task automatic test_bursts();
        logic [11:0] va[3] = '{12'h00C, 12'hFFE, 12'h020};
        logic [3:0]  vl[3] = '{4'd3, 4'd2, 4'd2};
        logic        vi[3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0]  vd[3] = '{8'h10, 8'h20, 8'h40};
        for (int v = 0; v < 3; v++) begin
            int acc;
            int x0 = xlog.size();
            int d0 = dlog.size();
            int n = int'(vl[v]) + 1;
            fork
                send_cmd(va[v], vl[v], vi[v], acc);
                feed(n, vd[v], 0);
            join
            repeat (8) @(negedge clk);
            checks++;
            if (xlog.size() - x0 !== n) begin
                errors++;
                $display("FAIL burst%0d_count: %0d strobes, required %0d", v, xlog.size() - x0, n);
            end else
                for (int k = 0; k < n; k++) begin
                    logic [11:0] ea;
                    logic [7:0]  ed;
                    ea = va[v] + (vi[v] ? 12'(k) : 12'd0);
                    ed = vd[v] + 8'(k);
                    checks++;
                    if (xlog[x0+k].c !== acc + 2 + 5 * k || xlog[x0+k].a !== ea || xlog[x0+k].d !== ed) begin
                        errors++;
                        $display("FAIL burst%0d_beat%0d: cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                                 v, k, xlog[x0+k].c, xlog[x0+k].a, xlog[x0+k].d, acc + 2 + 5 * k, ea, ed);
                    end
                end
            checks++;
            if (dlog.size() - d0 !== 1 || dlog[d0] !== acc + 5 * n) begin
                errors++;
                $display("FAIL burst%0d_done: %0d pulses, first at %0d, required 1 at %0d",
                         v, dlog.size() - d0, dlog.size() > d0 ? dlog[d0] : -1, acc + 5 * n);
            end
        end
    endtask

    task automatic test_stall();
        int acc;
        int x0 = xlog.size();
        fork
            begin
                send_cmd(12'h040, 4'd0, 1'b0, acc);
                repeat (2) @(negedge clk);
                checks++;
                if (bus.xfc !== 1'b0 || bus.address !== 12'h040 || bus.wr_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: xfc=%b addr=%h wr_ready=%b, required 0/040/1",
                             bus.xfc, bus.address, bus.wr_ready);
                end
            end
            feed(1, 8'h77, 4);
        join
        repeat (6) @(negedge clk);
        checks++;
        if (xlog.size() - x0 !== 1 || xlog[x0].c !== acc + 6 || xlog[x0].d !== 8'h77) begin
            errors++;
            $display("FAIL stall_strobe: %0d strobes, first at %0d, required 1 at %0d with data 77",
                     xlog.size() - x0, xlog.size() > x0 ? xlog[x0].c : -1, acc + 6);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        int x0 = xlog.size();
        int d0 = dlog.size();
        fork
            begin
                send_cmd(12'h080, 4'd0, 1'b0, acc1);
                checks++;
                if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_ready: cmd_ready=%b busy=%b, required 0/1", bus.cmd_ready, bus.busy);
                end
                send_cmd(12'h081, 4'd0, 1'b0, acc2);
            end
            feed(2, 8'h51, 0);
        join
        repeat (6) @(negedge clk);
        checks++;
        if (acc2 !== acc1 + 6) begin
            errors++;
            $display("FAIL b2b_accept: second command taken at %0d, required %0d", acc2, acc1 + 6);
        end
        checks++;
        if (dlog.size() - d0 !== 2 || dlog[d0] !== acc1 + 5) begin
            errors++;
            $display("FAIL b2b_done: %0d pulses, first at %0d, required 2 with first at %0d",
                     dlog.size() - d0, dlog.size() > d0 ? dlog[d0] : -1, acc1 + 5);
        end
        checks++;
        if (xlog.size() - x0 !== 2 || xlog[x0+1].c !== acc2 + 2 || xlog[x0+1].a !== 12'h081 || xlog[x0+1].d !== 8'h52) begin
            errors++;
            $display("FAIL b2b_second: %0d strobes, required 2 with second at %0d addr 081 data 52",
                     xlog.size() - x0, acc2 + 2);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int x0 = xlog.size();
        int d0 = dlog.size();
        fork
            send_cmd(12'h100, 4'd3, 1'b1, acc);
            feed(2, 8'h60, 0);
        join
        checks++;
        if (cyc !== acc + 6 || bus.busy !== 1'b1 || bus.address !== 12'h101) begin
            errors++;
            $display("FAIL rst_setup_point: cyc=%0d busy=%b addr=%h, required %0d/1/101", cyc, bus.busy, bus.address, acc + 6);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.xfc, bus.done, bus.busy, bus.address, bus.wdata} !== 23'd0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: xfc=%b done=%b busy=%b addr=%h wdata=%h cmd_ready=%b, required zeros and ready",
                     bus.xfc, bus.done, bus.busy, bus.address, bus.wdata, bus.cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (xlog.size() - x0 !== 1 || dlog.size() - d0 !== 0) begin
            errors++;
            $display("FAIL rst_abandon: %0d strobes %0d done pulses, required 1/0", xlog.size() - x0, dlog.size() - d0);
        end
        fork
            send_cmd(12'h055, 4'd0, 1'b0, acc);
            feed(1, 8'hAA, 0);
        join
        repeat (6) @(negedge clk);
        checks++;
        if (xlog.size() - x0 !== 2 || xlog[x0+1].c !== acc + 2 || xlog[x0+1].a !== 12'h055 || xlog[x0+1].d !== 8'hAA) begin
            errors++;
            $display("FAIL rst_recover: %0d strobes, required 2 with last at %0d addr 055 data aa",
                     xlog.size() - x0, acc + 2);
        end
    endtask

    task automatic test_param_corner();
        int xc[$];
        logic [11:0] xa[$];
        logic [7:0]  xd[$];
        int dc[$];
        int c0;
        int nb = 0;
        @(negedge clk);
        c0 = cyc;
        bus2.cmd_valid = 1'b1;
        bus2.cmd_addr  = 12'h0A0;
        bus2.cmd_len   = 4'd2;
        bus2.cmd_incr  = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            bus2.cmd_valid = 1'b0;
            if (bus2.xfc) begin
                xc.push_back(cyc - c0);
                xa.push_back(bus2.address);
                xd.push_back(bus2.wdata);
            end
            if (bus2.done) dc.push_back(cyc - c0);
            bus2.wr_valid = bus2.wr_ready;
            bus2.wr_data  = 8'h30 + 8'(nb);
            if (bus2.wr_ready) nb++;
        end
        bus2.wr_valid = 1'b0;
        checks++;
        if (xc.size() !== 3) begin
            errors++;
            $display("FAIL corner_count: %0d strobes, required 3", xc.size());
        end else
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (xc[k] !== 2 + 3 * k || xa[k] !== 12'h0A0 + 12'(k) || xd[k] !== 8'h30 + 8'(k)) begin
                    errors++;
                    $display("FAIL corner_beat%0d: rel=%0d addr=%h data=%h, required rel=%0d addr=%h data=%h",
                             k, xc[k], xa[k], xd[k], 2 + 3 * k, 12'h0A0 + 12'(k), 8'h30 + 8'(k));
                end
            end
        checks++;
        if (dc.size() !== 1 || dc[0] !== 10) begin
            errors++;
            $display("FAIL corner_done: %0d pulses, first at %0d, required 1 at 10",
                     dc.size(), dc.size() > 0 ? dc[0] : -1);
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL bus_stability: %0d violations, required 0", viol);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.cmd_incr = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data = '0;
        bus2.cmd_valid = 1'b0;
        bus2.cmd_addr = '0;
        bus2.cmd_len = '0;
        bus2.cmd_incr = 1'b0;
        bus2.wr_valid = 1'b0;
        bus2.wr_data = '0;
        test_reset();
        test_single();
        test_bursts();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        test_param_corner();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end
endmodule
